pipe_stage_reg: RTL

//  Parametrised pipeline stage register with valid/ready handshake, sync flush and stall counter.

---
 rtl/pipe_stage_reg.sv | 82 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with sync flush, saturating stall counter and optional skid entry
// Optional feature macro: PIPE_SKID_EN adds a one-beat skid entry so in_ready is registered
// (no combinational path from out_ready); without it in_ready = out_ready | !out_valid.
// Ports:
//   clk        rising-edge clock
//   rst        async reset, active-high (empties stage, out_data=RESET_VAL, stall_cnt=0)
//   flush      sync clear of stage contents; wins over the handshake, stall_cnt is kept
//   in_valid   upstream data valid
//   in_ready   stage can accept in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   registered payload
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] SKID  = 2'd2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_data;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] skid_data;
    assign in_ready  = state != SKID;
    assign load_data = state == SKID ? skid_data : in_data;
    // Beat accepted while the output is stalled parks in the skid entry.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            skid_data <= RESET_VAL;
        else if (!flush && state == FULL && accept && !out_ready)
            skid_data <= in_data;
`else
    assign in_ready  = out_ready | ~out_valid;
    assign load_data = in_data;
`endif
    // SKID is only reachable when the skid entry exists, since otherwise
    // in_ready is low whenever FULL meets a stalled output.
    always_comb
        state_nxt = flush            ? EMPTY :
                    state == EMPTY   ? (accept ? FULL : EMPTY) :
                    state == FULL    ? (accept ? (out_ready ? FULL : SKID)
                                               : (out_ready ? EMPTY : FULL)) :
                    out_ready        ? FULL : SKID;
    assign load = (state == EMPTY && accept) ||
                  (state == FULL && accept && out_ready) ||
                  (state == SKID && out_ready);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= EMPTY;
            out_data <= RESET_VAL;
        end else begin
            state <= state_nxt;
            if (flush)
                out_data <= RESET_VAL;
            else if (load)
                out_data <= load_data;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
endmodule
